alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, 64, watchdog limit in cycles for an outstanding ALU operation (used only with ALU_ARB_TIMEOUT_EN).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports, per requester i in {0,1}: req<i>_valid  input  1  operation request.
REQ-006 SHALL have ports: req<i>_a, req<i>_b  input  WIDTH  operands.
REQ-007 SHALL have port: req<i>_ready  output  1  request accepted this cycle.
REQ-008 SHALL have ports: rsp<i>_valid  output  1  result pulse; rsp<i>_data  output  WIDTH  result.
REQ-009 SHALL have ports: alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-010 SHALL have port: alu_in_valid  output  1  ALU start strobe.
REQ-011 SHALL have ports: alu_out  input  WIDTH  ALU result; alu_out_valid  input  1  ALU result strobe.
REQ-012 SHALL have ports: busy  output  1  not in IDLE; grant_id  output  1  requester currently owning the ALU; err  output  1  timeout pulse.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: if any req<i>_valid, SHALL select one requester, assert only its req<i>_ready combinationally in that cycle, latch its operands and grant_id at the edge, and go to ISSUE; otherwise stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: with both valid, grant the requester that is not last_grant; with one valid, grant it regardless of last_grant.
REQ-016 ISSUE: alu_in_valid SHALL be 1 for exactly this one cycle, with alu_a/alu_b equal to the latched operands; next state WAIT.
REQ-017 alu_a/alu_b SHALL hold the latched operands from ISSUE until the FSM leaves WAIT.
REQ-018 WAIT: on alu_out_valid=1, SHALL latch alu_out and go to RESP; otherwise stay.
REQ-019 RESP: rsp<grant_id>_valid SHALL be 1 for exactly one cycle with rsp<grant_id>_data = latched result; last_grant <= grant_id; next state IDLE.
REQ-020 Latency: handshake at edge N -> alu_in_valid high in cycle N+1; alu_out_valid sampled at edge M -> rsp valid high in cycle M+1; next acceptance no earlier than cycle M+2.
REQ-021 req<i>_ready SHALL be 0 in every state except IDLE; at most one req_ready and one rsp_valid SHALL be high per cycle.
REQ-022 alu_out_valid outside WAIT SHALL be ignored with no state change.
REQ-023 rsp<i>_data SHALL hold the last result delivered to requester i until its next response.
REQ-024 Responses SHALL have no backpressure; the requester must sample on the rsp_valid pulse.
REQ-025 busy SHALL be 1 in ISSUE, WAIT and RESP.

Reset
REQ-026 With rst=1 at an edge, SHALL enter IDLE, last_grant=1 (requester 0 wins first tie), grant_id=0.
REQ-027 Reset outputs: req_ready=0, rsp_valid=0, rsp_data=0, alu_in_valid=0, alu_a=alu_b=0, busy=0, err=0.
REQ-028 Reset during ISSUE/WAIT/RESP SHALL abort the operation: no response is issued and a later alu_out_valid is ignored.

Configuration
REQ-029 Macro ALU_ARB_TIMEOUT_EN defined: a cycle counter SHALL clear on entering WAIT; if TIMEOUT_CYCLES cycles elapse in WAIT without alu_out_valid, the block SHALL pulse err for one cycle, issue no response, set last_grant=grant_id, and return to IDLE.
REQ-030 Macro ALU_ARB_TIMEOUT_EN undefined: no counter; WAIT persists until alu_out_valid; err SHALL be tied to 0.

Verification
REQ-031 Single request: req0 a=5, b=7, ALU model latency 3 with out=a+b -> alu_in_valid 1 cycle after handshake, rsp0_valid pulse with data 12, rsp1_valid stays 0.
REQ-032 Simultaneous: req0 and req1 held valid after reset -> grant order 0,1,0,1 over four operations; each rsp goes to the matching requester.
REQ-033 Busy back-pressure: req1 raised while req0's operation is in WAIT -> req1_ready stays 0 until IDLE, then req1 is served next.
REQ-034 Reset mid-WAIT: rst pulsed while in WAIT, ALU strobes alu_out_valid afterwards -> no rsp_valid, busy=0, outputs at reset values.
REQ-035 Timeout (ALU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): ALU never responds -> err pulses once 8 cycles after entering WAIT, busy drops, next request accepted normally; without macro, busy stays 1 and err stays 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one multi-cycle ALU between two requesters
// Define ALU_ARB_TIMEOUT_EN to add a watchdog that abandons an ALU operation after TIMEOUT_CYCLES.
module alu_arbiter #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_in_valid,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_out_valid,
  output logic             busy,
  output logic             grant_id,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic             grant_id_q, grant_id_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic [WIDTH-1:0] rsp1_data_q, rsp1_data_d;
  logic             any_valid;
  logic             pick;
  logic             timed_out;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
    $error("alu_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  assign any_valid = req0_valid | req1_valid;
  // On a tie the requester that did not win last time goes next.
  assign pick      = (req0_valid & req1_valid) ? ~last_grant_q : ~req0_valid;

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req0_ready = ~pick;
          req1_ready = pick;
          grant_id_d = pick;
          a_d        = pick ? req1_a : req0_a;
          b_d        = pick ? req1_b : req0_b;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (alu_out_valid) begin
          if (grant_id_q) rsp1_data_d = alu_out;
          else            rsp0_data_d = alu_out;
          state_d = RESP;
        end else if (timed_out) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end
      RESP: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // cnt_q equals the number of WAIT cycles already completed before the current one.
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
      err_d = timed_out & ~alu_out_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  assign busy         = (state_q != IDLE);
  assign grant_id     = grant_id_q;
  assign alu_in_valid = (state_q == ISSUE);
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign rsp0_valid   = (state_q == RESP) & ~grant_id_q;
  assign rsp1_valid   = (state_q == RESP) & grant_id_q;
  assign rsp0_data    = rsp0_data_q;
  assign rsp1_data    = rsp1_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a transaction-timeline reference model
module tb_alu_arbiter;
  localparam int W   = 32;
  localparam int TO  = 8;
  localparam int BIG = 1 << 30;

  typedef struct {int cyc; int id; logic [W-1:0] a; logic [W-1:0] b;} iss_t;
  typedef struct {int cyc; int id; logic [W-1:0] data;} rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rv[2] = '{1'b0, 1'b0};
  logic [W-1:0] ra[2], rb[2];
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_data, rsp1_data, alu_a, alu_b;
  logic alu_in_valid;
  logic [W-1:0] alu_out = '0;
  logic alu_out_valid = 1'b0;
  logic busy, grant_id, err;

  assign req0_valid = rv[0];
  assign req1_valid = rv[1];
  assign req0_a = ra[0];
  assign req0_b = rb[0];
  assign req1_a = ra[1];
  assign req1_b = rb[1];

  alu_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_in_valid(alu_in_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .busy(busy), .grant_id(grant_id), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int ops = 0;
  int prob = 0;
  int lat_mode = -1;
  int busy_lo = 0, free_from = 0, wait_lo = BIG, wait_hi = BIG;
  int strobe_cyc = -1, err_cyc = -1, last_hs_cyc = -1;
  int last_g = 1, gid = 0;
  int hs_cnt[2] = '{0, 0};
  int seen[2] = '{0, 0};
  logic [W-1:0] strobe_data = '0, cur_a = '0, cur_b = '0;
  logic [W-1:0] last_data[2] = '{'0, '0};
  bit b_exp, e0, e1;
  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int dut_grants[$];
  iss_t ie, ne;
  rsp_t re;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // The ALU answers a+b after a chosen number of cycles, or never (lat_mode -2).
  task automatic schedule(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input int i_cyc);
    int lat;
    rsp_t r;
    if (lat_mode == -2) begin
      strobe_cyc = -1;
`ifdef ALU_ARB_TIMEOUT_EN
      wait_hi   = i_cyc + TO;
      free_from = i_cyc + TO + 1;
      err_cyc   = i_cyc + TO + 1;
`endif
    end else begin
      lat = (lat_mode < 0) ? int'($urandom_range(1, 6)) : lat_mode;
      strobe_cyc  = i_cyc + lat;
      strobe_data = a + b;
      wait_hi     = strobe_cyc;
      free_from   = strobe_cyc + 2;
      r.cyc = strobe_cyc + 1;
      r.id = id;
      r.data = a + b;
      rsp_q.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      iss_q.delete();
      rsp_q.delete();
      busy_lo = 0; free_from = 0; wait_lo = BIG; wait_hi = BIG; err_cyc = -1;
      last_g = 1; gid = 0; last_data[0] = '0; last_data[1] = '0;
    end else begin
      b_exp = (cyc >= busy_lo) && (cyc < free_from);
      e0 = 1'b0;
      e1 = 1'b0;
      if (!b_exp && (req0_valid || req1_valid)) begin
        if (req0_valid && req1_valid) begin
          if (last_g == 1) e0 = 1'b1; else e1 = 1'b1;
        end else if (req0_valid) e0 = 1'b1;
        else e1 = 1'b1;
      end
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("busy", busy, b_exp);
      chk("err", err, cyc == err_cyc);
      if (b_exp) chk("grant_id", grant_id, gid[0]);
      if (cyc >= wait_lo - 1 && cyc <= wait_hi) begin
        chk("alu_a_hold", alu_a, cur_a);
        chk("alu_b_hold", alu_b, cur_b);
      end
      if (alu_in_valid) begin
        if (iss_q.size() == 0) chk("alu_in_valid_spurious", alu_in_valid, 1'b0);
        else begin
          ie = iss_q.pop_front();
          chk("issue_cycle", cyc, ie.cyc);
          chk("issue_alu_a", alu_a, ie.a);
          chk("issue_alu_b", alu_b, ie.b);
          schedule(ie.id, ie.a, ie.b, cyc);
        end
      end else if (iss_q.size() > 0 && iss_q[0].cyc <= cyc) begin
        chk("alu_in_valid_missing", alu_in_valid, 1'b1);
        void'(iss_q.pop_front());
      end
      if (rsp0_valid || rsp1_valid) begin
        chk("rsp_onehot", rsp0_valid & rsp1_valid, 1'b0);
        if (rsp_q.size() == 0) chk("rsp_spurious", rsp0_valid | rsp1_valid, 1'b0);
        else begin
          re = rsp_q.pop_front();
          chk("rsp_cycle", cyc, re.cyc);
          chk("rsp_id", rsp1_valid, re.id[0]);
          last_data[re.id] = re.data;
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
        chk("rsp_missing", rsp0_valid | rsp1_valid, 1'b1);
        void'(rsp_q.pop_front());
      end
      chk("rsp0_data", rsp0_data, last_data[0]);
      chk("rsp1_data", rsp1_data, last_data[1]);
      if (req0_ready && req0_valid) dut_grants.push_back(0);
      if (req1_ready && req1_valid) dut_grants.push_back(1);
      if (e0 || e1) begin
        ne.id = e1 ? 1 : 0;
        ne.cyc = cyc + 1;
        ne.a = ra[ne.id];
        ne.b = rb[ne.id];
        iss_q.push_back(ne);
        busy_lo = cyc + 1; free_from = BIG; wait_lo = cyc + 2; wait_hi = BIG;
        last_g = ne.id; gid = ne.id; cur_a = ne.a; cur_b = ne.b;
        hs_cnt[ne.id]++;
        last_hs_cyc = cyc;
        ops++;
      end
    end
  end

  // ALU model; stray strobes are injected whenever no operation is waiting on the ALU.
  always @(posedge clk) begin
    #1;
    if (cyc == strobe_cyc) begin
      alu_out_valid = 1'b1;
      alu_out = strobe_data;
    end else if (!(cyc >= wait_lo && cyc <= wait_hi) && $urandom_range(0, 5) == 0) begin
      alu_out_valid = 1'b1;
      alu_out = $urandom;
    end else begin
      alu_out_valid = 1'b0;
      alu_out = $urandom;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hs_cnt[i] != seen[i]) begin
        seen[i] = hs_cnt[i];
        rv[i] = 1'b0;
      end
      if (!rv[i] && $urandom_range(0, 99) < prob) begin
        rv[i] = 1'b1;
        ra[i] = $urandom;
        rb[i] = $urandom;
      end
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_rsp0_data", rsp0_data, '0);
    chk("rst_rsp1_data", rsp1_data, '0);
    chk("rst_alu_in_valid", alu_in_valid, 1'b0);
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_b", alu_b, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_err", err, 1'b0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    check_reset_outputs();
    rst = 1'b0;
  endtask

  int exp_order[4];
  int g_base;
  int target;
  bit reached;

  initial begin
    exp_order = '{0, 1, 0, 1};
    ra[0] = '0; rb[0] = '0; ra[1] = '0; rb[1] = '0;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // single request, ALU latency 3
    lat_mode = 3;
    rv[0] = 1'b1; ra[0] = 32'd5; rb[0] = 32'd7;
    repeat (12) tick();
    chk("single_rsp0_data", rsp0_data, 32'd12);
    chk("single_rsp1_data", rsp1_data, '0);

    // both requesters held valid from reset: alternating grants starting with 0
    reset_pulse();
    g_base = dut_grants.size();
    lat_mode = -1;
    prob = 100;
    for (int k = 0; k < 200 && dut_grants.size() < g_base + 4; k++) tick();
    prob = 0;
    chk("tie_grant_count_reached", dut_grants.size() >= g_base + 4, 1'b1);
    for (int i = 0; i < 4 && g_base + i < dut_grants.size(); i++)
      chk("tie_grant_order", dut_grants[g_base + i], exp_order[i]);
    repeat (30) tick();

    // random traffic with random ALU latency
    prob = 35;
    target = ops + 150;
    for (int k = 0; k < 6000 && ops < target; k++) tick();
    chk("random_ops_reached", ops >= target, 1'b1);
    prob = 0;
    repeat (40) tick();

    // reset while WAIT, ALU strobe arrives afterwards
    lat_mode = 4;
    last_hs_cyc = -1;
    rv[1] = 1'b1; ra[1] = $urandom; rb[1] = $urandom;
    reached = 1'b0;
    for (int k = 0; k < 50 && !reached; k++) begin
      tick();
      reached = (last_hs_cyc >= 0) && (cyc == last_hs_cyc + 2);
    end
    chk("midwait_reached", reached, 1'b1);
    chk("midwait_busy", busy, 1'b1);
    reset_pulse();
    repeat (12) tick();
    chk("midwait_after_busy", busy, 1'b0);
    chk("midwait_after_rsp1_data", rsp1_data, '0);

    // ALU never answers
    lat_mode = -2;
    rv[0] = 1'b1; ra[0] = $urandom; rb[0] = $urandom;
    repeat (30) tick();
`ifdef ALU_ARB_TIMEOUT_EN
    chk("timeout_busy_dropped", busy, 1'b0);
`else
    chk("no_timeout_busy_stuck", busy, 1'b1);
    chk("no_timeout_err", err, 1'b0);
    reset_pulse();
`endif
    lat_mode = -1;
    rv[1] = 1'b1; ra[1] = $urandom; rb[1] = $urandom;
    repeat (20) tick();
    chk("final_idle", busy, 1'b0);
    chk("final_req1_served", rv[1], 1'b0);
    chk("iss_q_empty", iss_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
